// File: rtl/cmp_pkg.sv
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and constants for the 4-bit magnitude
//                comparator and the successive-approximation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

  // Default operand width of the comparator loop
  localparam int DEFAULT_W = 4;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Comparator result encoding, packed as {eq, gt, lt}
  localparam logic [2:0] CODE_EQ = 3'b100;
  localparam logic [2:0] CODE_GT = 3'b010;
  localparam logic [2:0] CODE_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/sar_search4.sv
// ============================================================================
//  Module      : sar_search4
//  Description : Binary-search controller closing a loop around a
//                combinational magnitude comparator. Drives the comparator
//                y operand and converges on the unknown x operand in at most
//                W+1 compare cycles. Result and status are held until the
//                next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search4
  import cmp_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] trial,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result
);

  // First candidate: midpoint of the full range, (2^W-1)>>1
  localparam logic [W-1:0] MID_INIT = {1'b0, {(W-1){1'b1}}};

  state_t       state;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [2:0]   code;
  logic [W:0]   up_sum;
  logic [W:0]   dn_sum;

  // Comparator code and the two candidate midpoints (W+1 bits, no wrap)
  always_comb begin
    code   = {cmp_eq, cmp_gt, cmp_lt};
    up_sum = {1'b0, trial} + {{W{1'b0}}, 1'b1} + {1'b0, hi};
    dn_sum = {1'b0, lo} + {1'b0, trial} - {{W{1'b0}}, 1'b1};
  end

  // Search FSM with registered outputs; done is a single-cycle pulse in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      lo     <= '0;
      hi     <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo    <= '0;
            hi    <= '1;
            trial <= MID_INIT;
            found <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end

        SEARCH: begin
          case (code)
            CODE_EQ: begin
              result <= trial;
              found  <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
            CODE_GT: begin
              // x above the top of the remaining range means x moved
              if (trial == hi) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                lo    <= trial + {{(W-1){1'b0}}, 1'b1};
                trial <= up_sum[W:1];
              end
            end
            CODE_LT: begin
              // x below the bottom of the remaining range means x moved
              if (trial == lo) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                hi    <= trial - {{(W-1){1'b0}}, 1'b1};
                trial <= dn_sum[W:1];
              end
            end
            default: begin
              // Non one-hot comparator output cannot be trusted
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          endcase
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_search4.sv
// ============================================================================
//  Module      : tb_sar_search4
//  Description : Self-checking bench for sar_search4. A behavioural 4-bit
//                comparator closes the loop; its output can be overridden
//                to inject invalid or inconsistent codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search4;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] trial;
  logic         cmp_eq;
  logic         cmp_gt;
  logic         cmp_lt;
  logic         busy;
  logic         done;
  logic         found;
  logic         err;
  logic [W-1:0] result;

  logic [W-1:0] x;
  logic         force_en;
  logic [2:0]   force_code;

  int tests_run;
  int tests_failed;
  int n;
  int dones;
  int trials [16];

  // Behavioural comparator with an injection override
  assign cmp_eq = force_en ? force_code[2] : (x == trial);
  assign cmp_gt = force_en ? force_code[1] : (x > trial);
  assign cmp_lt = force_en ? force_code[0] : (x < trial);

  sar_search4 #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .trial  (trial),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Start a search for xv and follow it until done (bounded). On return the
  // bench sits at the negedge after the done cycle, back in IDLE.
  task automatic run_search(input logic [W-1:0] xv, input bit hold);
    n     = 0;
    dones = 0;
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        dones++;
        break;
      end
      if (busy && n < 16) begin
        trials[n] = int'(trial);
        n++;
      end
      @(negedge clk);
    end
    if (dones == 0) check("search_timeout", 0, 1);
  endtask

  // Step one cycle past done and confirm the pulse was a single cycle
  task automatic after_done(input string tag);
    start = 1'b0;
    @(negedge clk);
    if (done) dones++;
    check(tag, dones, 1);
  endtask

  initial begin
    int exp15 [5];
    int exp0  [4];
    exp15 = '{7, 11, 13, 14, 15};
    exp0  = '{7, 3, 1, 0};

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    x            = '0;
    force_en     = 1'b0;
    force_code   = 3'b000;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_done", int'(done), 0);
    end
    check("rst_trial",  int'(trial),  0);
    check("rst_busy",   int'(busy),   0);
    check("rst_found",  int'(found),  0);
    check("rst_err",    int'(err),    0);
    check("rst_result", int'(result), 0);
    rst_n = 1'b1;

    // x = 7: hit on the first compare
    run_search(4'd7, 1'b0);
    check("x7_cycles", n, 1);
    check("x7_trial0", trials[0], 7);
    check("x7_found",  int'(found),  1);
    check("x7_result", int'(result), 7);
    check("x7_err",    int'(err),    0);
    after_done("x7_done_pulse");

    // x = 15: worst case upward
    run_search(4'd15, 1'b0);
    check("x15_cycles", n, 5);
    for (int i = 0; i < 5; i++) check($sformatf("x15_trial%0d", i), trials[i], exp15[i]);
    check("x15_found",  int'(found),  1);
    check("x15_result", int'(result), 15);
    after_done("x15_done_pulse");

    // x = 0: downward
    run_search(4'd0, 1'b0);
    check("x0_cycles", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("x0_trial%0d", i), trials[i], exp0[i]);
    check("x0_found",  int'(found),  1);
    check("x0_result", int'(result), 0);
    after_done("x0_done_pulse");

    // Sweep every operand value
    for (int v = 0; v < 16; v++) begin
      run_search(W'(v), 1'b0);
      check($sformatf("sweep%0d_found", v),  int'(found),  1);
      check($sformatf("sweep%0d_result", v), int'(result), v);
      check($sformatf("sweep%0d_err", v),    int'(err),    0);
      check($sformatf("sweep%0d_le5", v),    int'(n <= 5), 1);
      after_done($sformatf("sweep%0d_pulse", v));
    end

    // Invalid code 000 on the first compare
    force_en   = 1'b1;
    force_code = 3'b000;
    run_search(4'd9, 1'b0);
    check("z_cycles", n, 1);
    check("z_err",    int'(err),   1);
    check("z_found",  int'(found), 0);
    after_done("z_done_pulse");

    // gt stuck high: inconsistent once trial reaches the top of the range
    force_code = 3'b010;
    run_search(4'd9, 1'b0);
    check("gt_cycles",    n, 5);
    check("gt_lasttrial", trials[4], 15);
    check("gt_err",       int'(err),   1);
    check("gt_found",     int'(found), 0);
    after_done("gt_done_pulse");

    // Recovery: a clean search clears err
    force_en = 1'b0;
    run_search(4'd5, 1'b0);
    check("rec_err",    int'(err),    0);
    check("rec_result", int'(result), 5);
    after_done("rec_done_pulse");

    // start held through SEARCH: no restart, single done
    run_search(4'd15, 1'b1);
    check("hold_cycles", n, 5);
    check("hold_result", int'(result), 15);
    after_done("hold_done_pulse");
    repeat (3) begin
      @(negedge clk);
      check("hold_idle_done", int'(done), 0);
    end
    check("hold_idle_busy", int'(busy), 0);

    // Asynchronous reset mid-search
    @(negedge clk);
    x     = 4'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy_pre", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_trial",  int'(trial),  0);
    check("mid_busy",   int'(busy),   0);
    check("mid_result", int'(result), 0);
    check("mid_found",  int'(found),  0);
    check("mid_done",   int'(done),   0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mid_no_done", int'(done), 0);
    end
    check("mid_idle_busy", int'(busy), 0);

    // Clean search after reset
    run_search(4'd12, 1'b0);
    check("post_result", int'(result), 12);
    check("post_found",  int'(found),  1);
    after_done("post_done_pulse");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sar_search4.md
# sar_search4

Binary-search controller that drives the `y` operand of the 4-bit magnitude comparator and consumes its `eq`/`gt`/`lt` outputs. It finds the value of an unknown operand on the comparator's `x` input in at most W+1 compare cycles. It sits in front of and behind the comparator in a closed loop, giving the lab's first sequential successive-approximation stage. Result, found flag and error flag are held for downstream logic until the next search starts.

## Interface
- `W`, default 4: operand width; must match comparator width.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request a search; sampled only in IDLE.
- `trial`  output  W  registered candidate, wired to the comparator `y` input.
- `cmp_eq`  input  1  comparator: x == trial.
- `cmp_gt`  input  1  comparator: x > trial.
- `cmp_lt`  input  1  comparator: x < trial.
- `busy`  output  1  high in SEARCH.
- `done`  output  1  one-cycle pulse when a search ends.
- `found`  output  1  last search matched; held until next accepted start.
- `err`  output  1  last search hit an inconsistent or invalid compare; held until next accepted start.
- `result`  output  W  matched value (valid when `found`); held.

## Operation
- Internal registers: `lo`, `hi` (W bits each), state.
- Reset values: `trial`=0, `busy`=0, `done`=0, `found`=0, `err`=0, `result`=0, `lo`=0, `hi`=2^W-1, state=IDLE.
- FSM states:
  - IDLE: on `start`, set `lo`=0, `hi`=2^W-1, `trial`=(2^W-1)>>1, clear `found`/`err`, go to SEARCH.
  - SEARCH: sample the comparator each cycle and act on the result as listed below.
  - DONE: assert `done` for this single cycle, then return to IDLE.
- SEARCH actions by comparator code:
  - eq=1 only: `result`=`trial`, `found`=1, go to DONE.
  - gt=1 only: if `trial`==`hi`, set `err`=1 and go to DONE. Otherwise `lo`=`trial`+1 and `trial`=(`trial`+1+`hi`)>>1.
  - lt=1 only: if `trial`==`lo`, set `err`=1 and go to DONE. Otherwise `hi`=`trial`-1 and `trial`=(`lo`+`trial`-1)>>1.
  - Any code that is not one-hot (000, 011, 111, …): `err`=1, go to DONE.
- Midpoint arithmetic uses a W+1-bit sum, then shifts right by 1. There is no wrap: the guards above prevent `lo` overflowing past 2^W-1 and `hi` underflowing below 0.
- `start` is ignored in SEARCH and in DONE. It is not queued.
- `x` must stay stable from the accepted `start` until `done`. A change mid-search can produce a wrong `result` or set `err`; no other recovery is provided.
- Reset asserted mid-search returns every register to its reset value immediately (asynchronous). No `done` pulse is produced.

## Timing
- Comparator is combinational. `trial` is registered and the comparator outputs are sampled at the next rising edge.
- Cycle 0: edge sampling `start`=1 in IDLE. From cycle 1: SEARCH, with `trial`=2^(W-1)-1.
- Each SEARCH cycle costs exactly one compare. Maximum is W+1 SEARCH cycles (5 for W=4).
- `done` goes high in the cycle after the final compare and lasts exactly one cycle. `result`/`found`/`err` are valid from that same edge.
- Earliest possible back-to-back `start` is the cycle after `done`, i.e. when the FSM is back in IDLE.

## Structure
- Shared package `cmp_pkg`:
  - state enum: IDLE, SEARCH, DONE.
  - default width constant, 4.
  - localparam for the comparator result encoding {eq,gt,lt}.
- One sub-module is natural: the comparator itself, instantiated in the bench (not inside this block) to close the loop. The block contains no sub-modules.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles -> all outputs 0, `trial`=0, no `done`.
- x=7, start -> 1 SEARCH cycle (trial 7), `done` pulse, `found`=1, `result`=7.
- x=15, start -> trials 7,11,13,14,15 over 5 cycles, `found`=1, `result`=15. Then x=0, start -> trials 7,3,1,0, `result`=0.
- Sweep x=0..15 back-to-back -> every search `found`=1, `result`=x, SEARCH cycles ≤5, `err`=0.
- Bench forces {eq,gt,lt}=000 on the first SEARCH cycle -> `err`=1, `found`=0, `done` on the next cycle. Forcing gt=1 permanently -> `err`=1 when `trial`==15.
- `start` held high through SEARCH -> no restart, single `done`. `rst_n` pulsed low mid-search -> immediate return to reset values, no `done`.
